// File: rtl/mdu_pkg.sv
// Shared constants, func3 encodings and FSM state type for the M-extension
// divide unit.
package mdu_pkg;

    localparam int unsigned XLEN      = 32;
    localparam int unsigned TAG_W     = 5;
    localparam int unsigned DIV_ITERS = 32;

    localparam logic [2:0] FUNC3_DIV  = 3'b100;
    localparam logic [2:0] FUNC3_DIVU = 3'b101;
    localparam logic [2:0] FUNC3_REM  = 3'b110;
    localparam logic [2:0] FUNC3_REMU = 3'b111;

    typedef enum logic [1:0] {
        IDLE,
        CALC,
        DONE
    } div_state_e;

    // Unlisted func3 codes fall through to DIVU: unsigned, quotient.
    function automatic logic is_signed_op(input logic [2:0] f3);
        return (f3 == FUNC3_DIV) || (f3 == FUNC3_REM);
    endfunction

    function automatic logic is_rem_op(input logic [2:0] f3);
        return (f3 == FUNC3_REM) || (f3 == FUNC3_REMU);
    endfunction

endpackage

// File: rtl/div_unit_if.sv
// Request/response bundle between the execute stage (master) and the
// divide unit (slave).
interface div_unit_if;
    import mdu_pkg::*;

    logic             start;
    logic             kill;
    logic [2:0]       func3;
    logic [XLEN-1:0]  dividend;
    logic [XLEN-1:0]  divisor;
    logic [TAG_W-1:0] tag_in;
    logic             busy;
    logic             done;
    logic [XLEN-1:0]  result;
    logic [TAG_W-1:0] tag_out;

    modport master (
        output start, kill, func3, dividend, divisor, tag_in,
        input  busy, done, result, tag_out
    );

    modport slave (
        input  start, kill, func3, dividend, divisor, tag_in,
        output busy, done, result, tag_out
    );

endinterface

// File: rtl/div_abs.sv
// Conditional two's-complement negate; used for operand magnitudes and for
// the final sign fix of quotient/remainder.
module div_abs
    import mdu_pkg::*;
(
    input  logic [XLEN-1:0] in,
    input  logic            neg_en,
    output logic [XLEN-1:0] out
);

    assign out = neg_en ? -in : in;

endmodule

// File: rtl/div_unit.sv
// Iterative radix-2 restoring divider for DIV/DIVU/REM/REMU.
// Define DIV_EARLY_OUT_EN to finish divide-by-zero and signed overflow in one cycle.
module div_unit
    import mdu_pkg::*;
(
    input  logic       clk,
    input  logic       rst,
    div_unit_if.slave  bus
);

    div_state_e       state_q, state_d;
    logic [4:0]       count_q, count_d;
    logic [XLEN:0]    rem_q, rem_d;
    logic [XLEN-1:0]  quo_q, quo_d;
    logic [XLEN-1:0]  dvs_q, dvs_d;
    logic [2:0]       func3_q, func3_d;
    logic             qsign_q, qsign_d;
    logic             rsign_q, rsign_d;
    logic             spec_q, spec_d;
    logic [XLEN-1:0]  spec_res_q, spec_res_d;
    logic [TAG_W-1:0] tag_hold_q, tag_hold_d;
    logic [XLEN-1:0]  result_q, result_d;
    logic [TAG_W-1:0] tag_q, tag_d;

    logic             in_signed, in_rem;
    logic [XLEN-1:0]  dvd_mag, dvs_mag;
    logic             spec_hit;
    logic [XLEN-1:0]  spec_res;
    logic [XLEN:0]    shifted, diff, rem_step;
    logic [XLEN-1:0]  quo_step, raw_res, fixed_res;
    logic             fix_neg;

    assign in_signed = is_signed_op(bus.func3);
    assign in_rem    = is_rem_op(bus.func3);

    div_abs u_abs_dividend (
        .in     (bus.dividend),
        .neg_en (in_signed & bus.dividend[XLEN-1]),
        .out    (dvd_mag)
    );

    div_abs u_abs_divisor (
        .in     (bus.divisor),
        .neg_en (in_signed & bus.divisor[XLEN-1]),
        .out    (dvs_mag)
    );

    // Special cases are resolved from the raw operands at start time.
    always_comb begin
        spec_hit = 1'b0;
        spec_res = '0;
        if (bus.divisor == '0) begin
            spec_hit = 1'b1;
            spec_res = in_rem ? bus.dividend : '1;
        end else if (in_signed && bus.dividend == {1'b1, {(XLEN-1){1'b0}}} &&
                     bus.divisor == '1) begin
            spec_hit = 1'b1;
            spec_res = in_rem ? '0 : {1'b1, {(XLEN-1){1'b0}}};
        end
    end

    // One restoring step: shift {rem, quo}, trial-subtract the divisor.
    assign shifted  = {rem_q[XLEN-1:0], quo_q[XLEN-1]};
    assign diff     = shifted - {1'b0, dvs_q};
    assign rem_step = diff[XLEN] ? shifted : diff;
    assign quo_step = {quo_q[XLEN-2:0], ~diff[XLEN]};

    assign raw_res = is_rem_op(func3_q) ? rem_step[XLEN-1:0] : quo_step;
    assign fix_neg = is_signed_op(func3_q) & (is_rem_op(func3_q) ? rsign_q : qsign_q);

    div_abs u_sign_fix (
        .in     (raw_res),
        .neg_en (fix_neg),
        .out    (fixed_res)
    );

    always_comb begin
        state_d    = state_q;
        count_d    = count_q;
        rem_d      = rem_q;
        quo_d      = quo_q;
        dvs_d      = dvs_q;
        func3_d    = func3_q;
        qsign_d    = qsign_q;
        rsign_d    = rsign_q;
        spec_d     = spec_q;
        spec_res_d = spec_res_q;
        tag_hold_d = tag_hold_q;
        result_d   = result_q;
        tag_d      = tag_q;

        unique case (state_q)
            IDLE: begin
                if (bus.start && !bus.kill) begin
                    func3_d    = bus.func3;
                    dvs_d      = dvs_mag;
                    quo_d      = dvd_mag;
                    rem_d      = '0;
                    count_d    = '0;
                    qsign_d    = bus.dividend[XLEN-1] ^ bus.divisor[XLEN-1];
                    rsign_d    = bus.dividend[XLEN-1];
                    spec_d     = spec_hit;
                    spec_res_d = spec_res;
                    tag_hold_d = bus.tag_in;
`ifdef DIV_EARLY_OUT_EN
                    if (spec_hit) begin
                        state_d  = DONE;
                        result_d = spec_res;
                        tag_d    = bus.tag_in;
                    end else begin
                        state_d = CALC;
                    end
`else
                    state_d = CALC;
`endif
                end
            end
            CALC: begin
                rem_d   = rem_step;
                quo_d   = quo_step;
                count_d = count_q + 5'd1;
                if (count_q == 5'(DIV_ITERS - 1)) begin
                    state_d  = DONE;
                    result_d = spec_q ? spec_res_q : fixed_res;
                    tag_d    = tag_hold_q;
                end
            end
            DONE: begin
                state_d = IDLE;
            end
            default: begin
                state_d = IDLE;
            end
        endcase

        // A flush discards the op without touching the visible result.
        if (bus.kill) begin
            state_d  = IDLE;
            result_d = result_q;
            tag_d    = tag_q;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q    <= IDLE;
            count_q    <= '0;
            rem_q      <= '0;
            quo_q      <= '0;
            dvs_q      <= '0;
            func3_q    <= '0;
            qsign_q    <= 1'b0;
            rsign_q    <= 1'b0;
            spec_q     <= 1'b0;
            spec_res_q <= '0;
            tag_hold_q <= '0;
            result_q   <= '0;
            tag_q      <= '0;
        end else begin
            state_q    <= state_d;
            count_q    <= count_d;
            rem_q      <= rem_d;
            quo_q      <= quo_d;
            dvs_q      <= dvs_d;
            func3_q    <= func3_d;
            qsign_q    <= qsign_d;
            rsign_q    <= rsign_d;
            spec_q     <= spec_d;
            spec_res_q <= spec_res_d;
            tag_hold_q <= tag_hold_d;
            result_q   <= result_d;
            tag_q      <= tag_d;
        end
    end

    assign bus.busy    = (state_q != IDLE);
    assign bus.done    = (state_q == DONE);
    assign bus.result  = result_q;
    assign bus.tag_out = tag_q;

endmodule

// File: tb/tb_div_unit.sv
// Scoreboard bench for div_unit: the driver queues expected results, a
// negedge monitor checks result, tag and latency on every done pulse.
module tb_div_unit;
    import mdu_pkg::*;

    localparam int unsigned LAT_FULL = 32;
`ifdef DIV_EARLY_OUT_EN
    localparam int unsigned LAT_SPEC = 0;
`else
    localparam int unsigned LAT_SPEC = 32;
`endif

    typedef struct {
        logic [31:0] res;
        logic [4:0]  tag;
        int unsigned e0;
        int unsigned lat;
    } exp_t;

    logic        clk = 1'b0;
    logic        rst;
    int unsigned cyc = 0;
    int          checks = 0;
    int          errors = 0;
    exp_t        sb[$];
    exp_t        mon_e;
    logic [31:0] last_res;
    logic [4:0]  last_tag;

    div_unit_if bus ();

    div_unit dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h, expected %h", name, act, exp);
        end
    endtask

    always @(negedge clk) begin
        if (rst === 1'b0 && bus.done === 1'b1) begin
            if (sb.size() == 0) begin
                checks++;
                errors++;
                $display("FAIL spurious_done: done=1 at cycle %0d, expected no pending op", cyc);
            end else begin
                mon_e = sb.pop_front();
                check("result", bus.result, mon_e.res);
                check("tag_out", 32'(bus.tag_out), 32'(mon_e.tag));
                check("latency", cyc - mon_e.e0, mon_e.lat);
            end
        end
    end

    // Called at a negedge; returns at the negedge after the start edge E0.
    task automatic issue(input logic [2:0] f3, input logic [31:0] a, input logic [31:0] b,
                         input logic [4:0] tag, input logic [31:0] exp_res,
                         input int unsigned lat, input bit exp_done, output int unsigned e0);
        exp_t item;
        bus.func3    = f3;
        bus.dividend = a;
        bus.divisor  = b;
        bus.tag_in   = tag;
        bus.start    = 1'b1;
        @(posedge clk);
        #1;
        e0 = cyc;
        if (exp_done) begin
            item.res = exp_res;
            item.tag = tag;
            item.e0  = e0;
            item.lat = lat;
            sb.push_back(item);
            last_res = exp_res;
            last_tag = tag;
            check("busy_after_start", 32'(bus.busy), 32'd1);
        end
        @(negedge clk);
        bus.start = 1'b0;
    endtask

    // Waits (bounded) for done, then checks busy is low in the following cycle.
    task automatic finish_op(input string name);
        int n = 0;
        while (bus.done !== 1'b1 && n < 60) begin
            @(negedge clk);
            n++;
        end
        if (n >= 60) begin
            checks++;
            errors++;
            $display("FAIL %s_timeout: done=%b after %0d cycles, expected 1", name, bus.done, n);
        end else begin
            @(negedge clk);
            check({name, "_busy_low"}, 32'(bus.busy), 32'd0);
        end
    endtask

    task automatic run_op(input string name, input logic [2:0] f3, input logic [31:0] a,
                          input logic [31:0] b, input logic [4:0] tag,
                          input logic [31:0] exp_res, input int unsigned lat);
        int unsigned e0;
        issue(f3, a, b, tag, exp_res, lat, 1'b1, e0);
        finish_op(name);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation still running at %0t, expected finish", $time);
        $fatal(1);
    end

    initial begin
        int unsigned ea, eb, ex;
        bus.start    = 1'b0;
        bus.kill     = 1'b0;
        bus.func3    = 3'b000;
        bus.dividend = '0;
        bus.divisor  = '0;
        bus.tag_in   = '0;
        rst          = 1'b1;
        repeat (3) @(negedge clk);
        check("reset_busy", 32'(bus.busy), 32'd0);
        check("reset_done", 32'(bus.done), 32'd0);
        check("reset_result", bus.result, 32'd0);
        check("reset_tag", 32'(bus.tag_out), 32'd0);
        rst = 1'b0;
        @(negedge clk);

        run_op("divu_100_7", FUNC3_DIVU, 32'd100, 32'd7, 5'd1, 32'd14, LAT_FULL);
        run_op("remu_100_7", FUNC3_REMU, 32'd100, 32'd7, 5'd2, 32'd2, LAT_FULL);
        run_op("div_m7_2", FUNC3_DIV, 32'hFFFF_FFF9, 32'd2, 5'd3, 32'hFFFF_FFFD, LAT_FULL);
        run_op("rem_m7_2", FUNC3_REM, 32'hFFFF_FFF9, 32'd2, 5'd4, 32'hFFFF_FFFF, LAT_FULL);
        run_op("div_7_m2", FUNC3_DIV, 32'd7, 32'hFFFF_FFFE, 5'd5, 32'hFFFF_FFFD, LAT_FULL);
        run_op("rem_7_m2", FUNC3_REM, 32'd7, 32'hFFFF_FFFE, 5'd6, 32'd1, LAT_FULL);

        run_op("divu_by0", FUNC3_DIVU, 32'h1234, 32'd0, 5'd7, 32'hFFFF_FFFF, LAT_SPEC);
        run_op("rem_by0", FUNC3_REM, 32'h1234, 32'd0, 5'd8, 32'h1234, LAT_SPEC);
        run_op("div_ovf", FUNC3_DIV, 32'h8000_0000, 32'hFFFF_FFFF, 5'd9, 32'h8000_0000, LAT_SPEC);
        run_op("rem_ovf", FUNC3_REM, 32'h8000_0000, 32'hFFFF_FFFF, 5'd10, 32'd0, LAT_SPEC);
        run_op("div_big", FUNC3_DIV, 32'h7FFF_FFFF, 32'h8000_0000, 5'd11, 32'd0, LAT_FULL);

        // Kill during iteration 10: no done, visible result/tag untouched.
        issue(FUNC3_DIVU, 32'd50, 32'd5, 5'd12, 32'd10, LAT_FULL, 1'b0, ex);
        repeat (9) @(negedge clk);
        bus.kill = 1'b1;
        @(posedge clk);
        #1;
        bus.kill = 1'b0;
        check("kill_busy", 32'(bus.busy), 32'd0);
        check("kill_done", 32'(bus.done), 32'd0);
        check("kill_result", bus.result, last_res);
        check("kill_tag", 32'(bus.tag_out), 32'(last_tag));
        @(negedge clk);
        run_op("after_kill", FUNC3_DIVU, 32'd50, 32'd5, 5'd13, 32'd10, LAT_FULL);

        // start and kill in the same cycle: start dropped.
        bus.func3    = FUNC3_DIVU;
        bus.dividend = 32'd9;
        bus.divisor  = 32'd3;
        bus.tag_in   = 5'd14;
        bus.start    = 1'b1;
        bus.kill     = 1'b1;
        @(posedge clk);
        #1;
        check("start_kill_busy", 32'(bus.busy), 32'd0);
        @(negedge clk);
        bus.start = 1'b0;
        bus.kill  = 1'b0;
        @(negedge clk);

        // A stray start while busy must not disturb the running op.
        issue(FUNC3_DIVU, 32'd20, 32'd4, 5'd3, 32'd5, LAT_FULL, 1'b1, ex);
        repeat (4) @(negedge clk);
        bus.func3    = FUNC3_DIVU;
        bus.dividend = 32'd9;
        bus.divisor  = 32'd3;
        bus.tag_in   = 5'd9;
        bus.start    = 1'b1;
        @(negedge clk);
        bus.start = 1'b0;
        finish_op("start_while_busy");

        // Back-to-back on the first legal cycle.
        issue(FUNC3_DIVU, 32'hFFFF_FFFF, 32'd1, 5'd5, 32'hFFFF_FFFF, LAT_FULL, 1'b1, ea);
        finish_op("b2b_first");
        issue(FUNC3_REMU, 32'd10, 32'd3, 5'd6, 32'd1, LAT_FULL, 1'b1, eb);
        check("b2b_spacing", eb - ea, 32'd34);
        finish_op("b2b_second");

        // Reset in the middle of an iteration.
        issue(FUNC3_DIVU, 32'd100, 32'd7, 5'd2, 32'd14, LAT_FULL, 1'b0, ex);
        repeat (5) @(negedge clk);
        rst = 1'b1;
        @(posedge clk);
        #1;
        check("rst_busy", 32'(bus.busy), 32'd0);
        check("rst_done", 32'(bus.done), 32'd0);
        check("rst_result", bus.result, 32'd0);
        check("rst_tag", 32'(bus.tag_out), 32'd0);
        @(negedge clk);
        rst = 1'b0;

        repeat (40) @(negedge clk);
        check("scoreboard_empty", 32'(sb.size()), 32'd0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
